// File: rtl/dll_delay_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dll_delay_ctrl_if
// Purpose  : Bundles the phase-detector decision stream and the delay-line
//            code / lock status of the FMDLL delay controller.
// Ports    : comp, comp_valid, restart  - phase detector / supervisor side
//            Q, lock, state             - controller outputs
// Modports : slave  - the delay controller (consumes comp, drives Q)
//            master - the environment (drives comp, observes Q)
// Revision : 1.0 - initial release
// ============================================================================
interface dll_delay_ctrl_if #(
  parameter int W = 10
);
  logic         comp;
  logic         comp_valid;
  logic         restart;
  logic [W-1:0] Q;
  logic         lock;
  logic [1:0]   state;

  modport slave (
    input  comp,
    input  comp_valid,
    input  restart,
    output Q,
    output lock,
    output state
  );

  modport master (
    output comp,
    output comp_valid,
    output restart,
    input  Q,
    input  lock,
    input  state
  );
endinterface
`default_nettype wire

// File: rtl/dll_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dll_delay_ctrl
// Purpose  : Closes the FMDLL loop. Consumes the phase detector COMP bit and
//            steers the delay-line code Q: a coarse binary (SAR) search,
//            followed by a majority-filtered bang-bang tracking loop with
//            lock detection based on direction reversals.
// Ports    : clk_ext     in  1  reference clock, rising edge
//            rst_n       in  1  asynchronous active-low reset
//            bus.comp        in  1  PD decision, 1 = delay too short
//            bus.comp_valid  in  1  one strobe per DIV_M period
//            bus.restart     in  1  re-enter the acquisition sequence
//            bus.Q           out W  delay-line code (registered)
//            bus.lock        out 1  loop locked (registered)
//            bus.state       out 2  0=IDLE 1=SEARCH 2=TRACK
// Config   : DLL_DELAY_CTRL_SAR_EN - when defined, the SAR search state is
//            built; otherwise acquisition starts tracking directly from
//            mid-scale.
// Revision : 1.0 - initial release
// ============================================================================
module dll_delay_ctrl #(
  parameter int W         = 10,
  parameter int FILT_LEN  = 3,
  parameter int SETTLE    = 2,
  parameter int LOCK_CNT  = 4,
  parameter int LOCK_LOSS = 4
) (
  input  logic              clk_ext,
  input  logic              rst_n,
  dll_delay_ctrl_if.slave   bus
);

  // --------------------------------------------------------------------------
  // Derived widths and typed constants
  // --------------------------------------------------------------------------
  localparam int c_FW = $clog2(FILT_LEN + 1);   // window sample/ones counters
  localparam int c_RW = $clog2(LOCK_CNT + 1);   // reversal counter
  localparam int c_LW = $clog2(LOCK_LOSS + 1);  // run counter

  localparam logic [W-1:0]    c_MID        = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]    c_QMAX       = {W{1'b1}};
  localparam logic [2:0]      c_SETTLE     = 3'(SETTLE);
  localparam logic [c_FW-1:0] c_FILT_LAST  = c_FW'(FILT_LEN - 1);
  localparam logic [c_FW-1:0] c_FILT_HALF  = c_FW'(FILT_LEN / 2);
  localparam logic [c_RW-1:0] c_LOCK_CNT   = c_RW'(LOCK_CNT);
  localparam logic [c_LW-1:0] c_LOCK_LOSS  = c_LW'(LOCK_LOSS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_TRACK  = 2'd2
  } state_t;

  // Acquisition entry point after reset or restart.
`ifdef DLL_DELAY_CTRL_SAR_EN
  localparam state_t c_ENTRY = ST_SEARCH;
  localparam int     c_IW    = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0]    c_ONE      = {{(W-1){1'b0}}, 1'b1};
  localparam logic [c_IW-1:0] c_IDX_TOP  = c_IW'(W - 1);
`else
  localparam state_t c_ENTRY = ST_TRACK;
`endif

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t             r_state;
  logic [W-1:0]       r_q;
  logic               r_lock;
  logic [2:0]         r_settle;   // strobes still to discard after a Q write
  logic [c_FW-1:0]    r_ones;     // ones seen in the current window
  logic [c_FW-1:0]    r_cnt;      // samples seen in the current window
  logic [c_RW-1:0]    r_rev;      // consecutive direction reversals
  logic [c_LW-1:0]    r_run;      // length of current same-direction run; 0 = no step yet
  logic               r_dir;      // direction of the previous step, 1 = up
`ifdef DLL_DELAY_CTRL_SAR_EN
  logic [c_IW-1:0]    r_bit_idx;  // SAR bit under trial
`endif

  // --------------------------------------------------------------------------
  // Tracking decision
  // --------------------------------------------------------------------------
  logic [c_FW-1:0]    w_ones_total;
  logic               w_win_done;
  logic               w_up;
  logic               w_sat;
  logic [c_RW-1:0]    w_rev_nxt;
  logic [c_LW-1:0]    w_run_nxt;

  assign w_ones_total = r_ones + {{(c_FW-1){1'b0}}, bus.comp};
  assign w_win_done   = (r_cnt == c_FILT_LAST);
  assign w_up         = (w_ones_total > c_FILT_HALF);
  // A step that would leave the code range is still a step for the lock
  // bookkeeping, but Q and the settle counter are left untouched.
  assign w_sat        = w_up ? (r_q == c_QMAX) : (r_q == '0);

  // Reversal/run bookkeeping for the step being decided this cycle.
  always_comb begin
    w_rev_nxt = r_rev;
    w_run_nxt = r_run;
    if (r_run == '0) begin
      // First step after acquisition entry has no predecessor to compare with.
      w_run_nxt = {{(c_LW-1){1'b0}}, 1'b1};
    end else if (w_up != r_dir) begin
      w_run_nxt = {{(c_LW-1){1'b0}}, 1'b1};
      w_rev_nxt = (r_rev == c_LOCK_CNT) ? r_rev : r_rev + 1'b1;
    end else begin
      w_rev_nxt = '0;
      w_run_nxt = (r_run == c_LOCK_LOSS) ? r_run : r_run + 1'b1;
    end
  end

`ifdef DLL_DELAY_CTRL_SAR_EN
  // --------------------------------------------------------------------------
  // SAR trial: resolve the bit under test from comp, then tentatively set the
  // next lower bit.
  // --------------------------------------------------------------------------
  logic [W-1:0] w_bit;
  logic [W-1:0] w_sar_q;

  always_comb begin
    w_bit   = c_ONE << r_bit_idx;
    w_sar_q = bus.comp ? r_q : (r_q & ~w_bit);
    if (r_bit_idx != '0) begin
      w_sar_q = w_sar_q | (w_bit >> 1);
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Main state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_q       <= '0;
      r_lock    <= 1'b0;
      r_settle  <= '0;
      r_ones    <= '0;
      r_cnt     <= '0;
      r_rev     <= '0;
      r_run     <= '0;
      r_dir     <= 1'b0;
`ifdef DLL_DELAY_CTRL_SAR_EN
      r_bit_idx <= '0;
`endif
    end else if ((r_state == ST_IDLE) || bus.restart) begin
      // Acquisition entry; restart beats a coincident comp_valid so the
      // sample of this cycle is dropped.
      r_state   <= c_ENTRY;
      r_q       <= c_MID;
      r_lock    <= 1'b0;
      r_settle  <= c_SETTLE;
      r_ones    <= '0;
      r_cnt     <= '0;
      r_rev     <= '0;
      r_run     <= '0;
      r_dir     <= 1'b0;
`ifdef DLL_DELAY_CTRL_SAR_EN
      r_bit_idx <= c_IDX_TOP;
`endif
    end else if (bus.comp_valid) begin
      if (r_settle != '0) begin
        // Delay line still settling after the last code change.
        r_settle <= r_settle - 1'b1;
      end else begin
        case (r_state)
`ifdef DLL_DELAY_CTRL_SAR_EN
          ST_SEARCH: begin
            // Every SAR decision writes Q, including the last one.
            r_q      <= w_sar_q;
            r_settle <= c_SETTLE;
            if (r_bit_idx == '0) begin
              r_state <= ST_TRACK;
            end else begin
              r_bit_idx <= r_bit_idx - 1'b1;
            end
          end
`endif
          ST_TRACK: begin
            if (w_win_done) begin
              r_ones <= '0;
              r_cnt  <= '0;
              r_rev  <= w_rev_nxt;
              r_run  <= w_run_nxt;
              r_dir  <= w_up;
              if (w_rev_nxt == c_LOCK_CNT) begin
                r_lock <= 1'b1;
              end else if (w_run_nxt == c_LOCK_LOSS) begin
                r_lock <= 1'b0;
              end
              if (!w_sat) begin
                r_q      <= w_up ? (r_q + 1'b1) : (r_q - 1'b1);
                r_settle <= c_SETTLE;
              end
            end else begin
              r_ones <= w_ones_total;
              r_cnt  <= r_cnt + 1'b1;
            end
          end
          default: begin
            // IDLE is handled above; nothing to do.
          end
        endcase
      end
    end
  end

  assign bus.Q     = r_q;
  assign bus.lock  = r_lock;
  assign bus.state = r_state;

endmodule
`default_nettype wire
